fetch_sequencer: RTL and testbench

Instruction fetch and issue controller for the 16-bit processor core. It reads instruction words from a synchronous program ROM and presents each one to the core on DIN with a one-cycle Run pulse. It waits for the core's Done before fetching the next word, and provides free-run, single-step, halt-opcode and Done-watchdog control. It sits between the program memory and the core's DIN/Run/Done interface.

---
 rtl/proc_pkg.sv | 44 ++++
 rtl/fetch_watchdog.sv | 32 +++
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor core: opcodes, instruction layout
// and the fetch sequencer state type.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Field positions: opcode [15:13], imm [12], rX [11:9], rY [2:0].
    typedef struct packed {
        logic [2:0] opcode;
        logic       imm;
        logic [2:0] rx;
        logic [5:0] mid;
        logic [2:0] ry;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT,
        ST_PAUSE,
        ST_HALT,
        ST_ERR
    } fetch_state_t;

    function automatic logic is_halt(input instr_t word);
        return word.opcode == OP_HALT;
    endfunction

    // Number of core steps an opcode takes; mv/mvt are two-step, add/sub four-step.
    function automatic int unsigned op_steps(input logic [2:0] opcode);
        case (opcode)
            OP_MV, OP_MVT:  return 2;
            OP_ADD, OP_SUB: return 4;
            default:        return 0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Done watchdog for the fetch sequencer: counts cycles since the Run pulse and
// flags expiry on the cycle whose increment would reach TIMEOUT.
module fetch_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count_q <= '0;
        end else if (clr) begin
            // The Run cycle itself counts as the first elapsed cycle.
            count_q <= CNT_W'(1);
        end else if (en && count_q != CNT_W'(TIMEOUT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expire = en && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller between the program ROM and the core's DIN/Run/Done.
// Define FETCH_PERF_EN to add the 32-bit Retired instruction counter output.
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_addr,
    input  logic              Step_mode,
    input  logic              Step,
    output logic              Mem_rd,
    output logic [ADDR_W-1:0] Mem_addr,
    input  logic [15:0]       Mem_rdata,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Err,
    output logic [ADDR_W-1:0] PC
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       Retired
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_buf_q;

    logic accept_start;
    logic retire;
    logic wd_clr;
    logic wd_en;
    logic wd_expire;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        retire       = 1'b0;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT, ST_ERR: begin
                if (Start) begin
                    accept_start = 1'b1;
                    state_d      = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = is_halt(Mem_rdata) ? ST_HALT : ST_ISSUE;
            end
            ST_ISSUE: begin
                wd_clr  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                // Done takes priority over a watchdog expiry in the same cycle.
                if (Done) begin
                    retire  = 1'b1;
                    state_d = Step_mode ? ST_PAUSE : ST_RD;
                end else if (wd_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_PAUSE: begin
                if (Step || !Step_mode) begin
                    state_d = ST_RD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pc_q <= '0;
        end else if (accept_start) begin
            pc_q <= Start_addr;
        end else if (retire) begin
            pc_q <= pc_q + ADDR_W'(1);
        end
    end

    // The halt word is latched too; it simply never reaches the core as a Run.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ir_buf_q <= '0;
        end else if (state_q == ST_LATCH) begin
            ir_buf_q <= Mem_rdata;
        end
    end

    assign Mem_rd   = (state_q == ST_RD);
    assign Run      = (state_q == ST_ISSUE);
    assign Busy     = (state_q == ST_RD) || (state_q == ST_LATCH) ||
                      (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign Halted   = (state_q == ST_HALT);
    assign Err      = (state_q == ST_ERR);
    assign Mem_addr = pc_q;
    assign PC       = pc_q;
    assign DIN      = ir_buf_q;

`ifdef FETCH_PERF_EN
    logic [31:0] retired_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            retired_q <= '0;
        end else if (accept_start) begin
            retired_q <= '0;
        end else if (retire && retired_q != '1) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign Retired = retired_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: ROM and core models, directed scenarios
// and randomized programs checked against an instruction-level timeline model.
`timescale 1ns/1ps
module tb_fetch_sequencer;
    import proc_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 15;

    logic              Clock = 1'b0;
    logic              Resetn = 1'b1;
    logic              Start = 1'b0;
    logic [ADDR_W-1:0] Start_addr = '0;
    logic              Step_mode = 1'b0;
    logic              Step = 1'b0;
    logic              Mem_rd;
    logic [ADDR_W-1:0] Mem_addr;
    logic [15:0]       Mem_rdata = '0;
    logic [15:0]       DIN;
    logic              Run;
    logic              Done;
    logic              Busy;
    logic              Halted;
    logic              Err;
    logic [ADDR_W-1:0] PC;
`ifdef FETCH_PERF_EN
    logic [31:0]       Retired;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] rom [256];
    int          delay_q[$];
    int          core_cnt = 0;
    int          run_q[$];
    logic [15:0] din_q[$];
    logic [15:0] wait_din_q[$];
    int          rd_q[$];
    logic        prev_run = 1'b0;

    fetch_sequencer #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .Start_addr (Start_addr),
        .Step_mode  (Step_mode),
        .Step       (Step),
        .Mem_rd     (Mem_rd),
        .Mem_addr   (Mem_addr),
        .Mem_rdata  (Mem_rdata),
        .DIN        (DIN),
        .Run        (Run),
        .Done       (Done),
        .Busy       (Busy),
        .Halted     (Halted),
        .Err        (Err),
        .PC         (PC)
`ifdef FETCH_PERF_EN
        ,
        .Retired    (Retired)
`endif
    );

    always #5 Clock = ~Clock;

    // Cycle counter and synchronous ROM (data valid the cycle after Mem_rd).
    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (Mem_rd) Mem_rdata <= rom[Mem_addr];
    end

    // Core model: Done asserted d cycles after the Run cycle, d taken from delay_q.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn || Err || Halted) core_cnt <= 0;
        else if (Run) core_cnt <= (delay_q.size() > 0) ? delay_q.pop_front() : 1;
        else if (core_cnt > 0) core_cnt <= core_cnt - 1;
    end
    assign Done = (core_cnt == 1);

    always @(negedge Clock) begin
        if (Run) begin
            run_q.push_back(cyc);
            din_q.push_back(DIN);
        end
        if (prev_run) wait_din_q.push_back(DIN);
        if (Mem_rd) rd_q.push_back(cyc);
        prev_run <= Run;
    end

    task automatic clear_logs();
        run_q.delete();
        din_q.delete();
        wait_din_q.delete();
        rd_q.delete();
        delay_q.delete();
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a, output int c);
        @(posedge Clock);
        #1;
        Start = 1'b1;
        Start_addr = a;
        c = cyc;
        @(posedge Clock);
        #1;
        Start = 1'b0;
    endtask

    task automatic pulse_step(output int s);
        @(posedge Clock);
        #1;
        Step = 1'b1;
        s = cyc;
        @(posedge Clock);
        #1;
        Step = 1'b0;
    endtask

    task automatic at_cycle(input int n);
        for (int i = 0; i < 500; i++) begin
            @(negedge Clock);
            if (cyc >= n) break;
        end
    endtask

    task automatic wait_done(input int budget, output int end_c);
        end_c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (Halted || Err) begin
                end_c = cyc;
                break;
            end
        end
        n_checks++;
        if (end_c < 0) begin
            $display("FAIL wait_done: no Halted/Err within %0d cycles", budget);
            n_fail++;
        end
    endtask

    function automatic int q_at(input int idx, input int q[$]);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 256; i++) rom[i] = {OP_HALT, 13'd0};
        #2 Resetn = 1'b0;
        #2;
        n_checks++; if ({Run, Mem_rd, Busy, Halted, Err} !== 5'b0) begin
            $display("FAIL reset_flags: got %b expected 00000", {Run, Mem_rd, Busy, Halted, Err}); n_fail++; end
        n_checks++; if (PC !== 8'h00 || Mem_addr !== 8'h00) begin
            $display("FAIL reset_pc: got PC=%h Mem_addr=%h expected 00", PC, Mem_addr); n_fail++; end
        n_checks++; if (DIN !== 16'h0000) begin
            $display("FAIL reset_din: got %h expected 0000", DIN); n_fail++; end
`ifdef FETCH_PERF_EN
        n_checks++; if (Retired !== 32'd0) begin
            $display("FAIL reset_retired: got %0d expected 0", Retired); n_fail++; end
`endif
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        n_checks++; if ({Busy, Mem_rd, Run} !== 3'b0 || PC !== 8'h00) begin
            $display("FAIL idle_hold: got busy/rd/run=%b PC=%h expected 000/00", {Busy, Mem_rd, Run}, PC); n_fail++; end
    endtask

    task automatic test_free_run();
        int c, e;
        rom[0] = {OP_MV,  1'b1, 3'd0, 9'd5};
        rom[1] = {OP_MVT, 1'b1, 3'd1, 9'h012};
        rom[2] = {OP_HALT, 13'd0};
        clear_logs();
        delay_q = '{1, 1};
        pulse_start(8'h00, c);
        wait_done(60, e);
        n_checks++; if (q_at(0, run_q) != c + 3 || q_at(1, run_q) != c + 7 || run_q.size() != 2) begin
            $display("FAIL free_run_runs: got n=%0d first=%0d second=%0d expected 2/%0d/%0d",
                     run_q.size(), q_at(0, run_q), q_at(1, run_q), c + 3, c + 7); n_fail++; end
        n_checks++; if (wait_din_q.size() != 2 || wait_din_q[0] !== rom[0] || wait_din_q[1] !== rom[1]) begin
            $display("FAIL free_run_din: got n=%0d expected WAIT DIN %h then %h", wait_din_q.size(), rom[0], rom[1]); n_fail++; end
        n_checks++; if (Halted !== 1'b1 || Err !== 1'b0 || PC !== 8'h02 || e != c + 11) begin
            $display("FAIL free_run_halt: got Halted=%b Err=%b PC=%h at %0d expected 1/0/02 at %0d", Halted, Err, PC, e, c + 11); n_fail++; end
        n_checks++; if (rd_q.size() != 3 || q_at(2, rd_q) != c + 9) begin
            $display("FAIL free_run_rd: got n=%0d last=%0d expected 3/%0d", rd_q.size(), q_at(2, rd_q), c + 9); n_fail++; end
`ifdef FETCH_PERF_EN
        n_checks++; if (Retired !== 32'd2) begin
            $display("FAIL free_run_retired: got %0d expected 2", Retired); n_fail++; end
`endif
    endtask

    task automatic test_add_timing();
        int c, e;
        instr_t w;
        w = '0;
        w.opcode = OP_ADD; w.rx = 3'd2; w.ry = 3'd3;
        rom[8'h10] = w;
        rom[8'h11] = {OP_HALT, 13'h1abc};
        clear_logs();
        delay_q = '{3};
        pulse_start(8'h10, c);
        wait_done(60, e);
        n_checks++; if (q_at(0, run_q) != c + 3 || q_at(1, rd_q) != q_at(0, run_q) + 4) begin
            $display("FAIL add_timing: got Run=%0d next Mem_rd=%0d expected %0d/%0d", q_at(0, run_q), q_at(1, rd_q), c + 3, c + 7); n_fail++; end
        n_checks++; if (PC !== 8'h11 || Halted !== 1'b1) begin
            $display("FAIL add_pc: got PC=%h Halted=%b expected 11/1", PC, Halted); n_fail++; end
    endtask

    task automatic test_step_mode();
        int c, c2, s, m, e;
        clear_logs();
        delay_q = '{1, 1};
        Step_mode = 1'b1;
        pulse_start(8'h00, c);
        at_cycle(c + 10);
        n_checks++; if (rd_q.size() != 1 || Busy !== 1'b0 || PC !== 8'h01 || Halted !== 1'b0) begin
            $display("FAIL step_pause1: got rds=%0d Busy=%b PC=%h expected 1/0/01", rd_q.size(), Busy, PC); n_fail++; end
        pulse_start(8'h40, c2);
        at_cycle(c2 + 4);
        n_checks++; if (rd_q.size() != 1 || PC !== 8'h01 || Mem_addr !== 8'h01) begin
            $display("FAIL step_start_ignored: got rds=%0d PC=%h expected 1/01", rd_q.size(), PC); n_fail++; end
        pulse_step(s);
        at_cycle(s + 8);
        n_checks++; if (rd_q.size() != 2 || q_at(1, rd_q) != s + 1 || PC !== 8'h02 || Busy !== 1'b0) begin
            $display("FAIL step_pause2: got rds=%0d rd=%0d PC=%h expected 2/%0d/02", rd_q.size(), q_at(1, rd_q), PC, s + 1); n_fail++; end
        @(posedge Clock);
        #1;
        Step_mode = 1'b0;
        m = cyc;
        wait_done(20, e);
        n_checks++; if (q_at(2, rd_q) != m + 1 || e != m + 3 || Halted !== 1'b1 || PC !== 8'h02) begin
            $display("FAIL step_clear_mode: got rd=%0d halt=%0d PC=%h expected %0d/%0d/02", q_at(2, rd_q), e, PC, m + 1, m + 3); n_fail++; end
    endtask

    task automatic test_watchdog();
        int c, c2, e;
        rom[8'h20] = {OP_MV, 1'b1, 3'd4, 9'd7};
        rom[8'h04] = {OP_HALT, 13'd0};
        clear_logs();
        delay_q = '{1000};
        pulse_start(8'h20, c);
        at_cycle(c + 3 + TIMEOUT - 1);
        n_checks++; if (Err !== 1'b0 || Busy !== 1'b1) begin
            $display("FAIL wd_early: got Err=%b Busy=%b expected 0/1", Err, Busy); n_fail++; end
        at_cycle(c + 3 + TIMEOUT);
        n_checks++; if (Err !== 1'b1 || PC !== 8'h20 || Busy !== 1'b0) begin
            $display("FAIL wd_expire: got Err=%b PC=%h Busy=%b expected 1/20/0", Err, PC, Busy); n_fail++; end
        pulse_start(8'h04, c2);
        at_cycle(c2 + 1);
        n_checks++; if (Err !== 1'b0 || Mem_addr !== 8'h04 || Mem_rd !== 1'b1) begin
            $display("FAIL wd_restart: got Err=%b Mem_addr=%h Mem_rd=%b expected 0/04/1", Err, Mem_addr, Mem_rd); n_fail++; end
        wait_done(20, e);
        // Done landing on the expiry cycle must still retire the instruction.
        rom[8'h30] = {OP_SUB, 1'b0, 3'd1, 6'd0, 3'd2};
        rom[8'h31] = {OP_HALT, 13'd0};
        clear_logs();
        delay_q = '{TIMEOUT - 1};
        pulse_start(8'h30, c);
        wait_done(60, e);
        n_checks++; if (Halted !== 1'b1 || Err !== 1'b0 || PC !== 8'h31) begin
            $display("FAIL wd_done_wins: got Halted=%b Err=%b PC=%h expected 1/0/31", Halted, Err, PC); n_fail++; end
    endtask

    task automatic test_wrap_reset();
        int c, e;
        rom[8'hFF] = {OP_MV, 1'b1, 3'd3, 9'd1};
        clear_logs();
        delay_q = '{1, 1, 1};
        pulse_start(8'hFF, c);
        at_cycle(c + 5);
        n_checks++; if (PC !== 8'h00 || Mem_rd !== 1'b1 || Mem_addr !== 8'h00) begin
            $display("FAIL wrap_pc: got PC=%h Mem_rd=%b expected 00/1", PC, Mem_rd); n_fail++; end
        wait_done(60, e);
        clear_logs();
        delay_q = '{1000};
        pulse_start(8'hFF, c);
        at_cycle(c + 4);
        Resetn = 1'b0;
        #1;
        n_checks++; if ({Run, Busy, Mem_rd, Halted, Err} !== 5'b0 || DIN !== 16'h0000 || PC !== 8'h00) begin
            $display("FAIL reset_in_wait: got flags=%b DIN=%h PC=%h expected 00000/0000/00",
                     {Run, Busy, Mem_rd, Halted, Err}, DIN, PC); n_fail++; end
`ifdef FETCH_PERF_EN
        n_checks++; if (Retired !== 32'd0) begin
            $display("FAIL reset_in_wait_retired: got %0d expected 0", Retired); n_fail++; end
`endif
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            logic [ADDR_W-1:0] a, p, pc;
            int n, c, t, k, e, exp_end, retired;
            bit exp_err;
            int exp_run[$];
            logic [15:0] exp_din[$];
            int dl[$];
            a = ADDR_W'($urandom_range(0, 255));
            n = $urandom_range(1, 6);
            p = a;
            for (int i = 0; i < n; i++) begin
                rom[p] = {3'($urandom_range(0, 6)), 13'($urandom)};
                p = p + 8'd1;
                dl.push_back(($urandom_range(0, 4) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                                         : $urandom_range(1, 6));
            end
            rom[p] = {OP_HALT, 13'($urandom)};
            clear_logs();
            delay_q = dl;
            pulse_start(a, c);
            // Timeline: each fetch costs RD+LATCH, Run follows, next RD comes one cycle after Done.
            t = c + 1; pc = a; k = 0; exp_err = 0; exp_end = -1; retired = 0;
            for (int g = 0; g < 16; g++) begin
                if (rom[pc][15:13] == OP_HALT) begin
                    exp_end = t + 2;
                    break;
                end
                exp_run.push_back(t + 2);
                exp_din.push_back(rom[pc]);
                if (dl[k] <= TIMEOUT - 1) begin
                    t = t + 3 + dl[k];
                    pc = pc + 8'd1;
                    k++;
                    retired++;
                end else begin
                    exp_end = t + 2 + TIMEOUT;
                    exp_err = 1'b1;
                    break;
                end
            end
            wait_done(400, e);
            n_checks++; if (e != exp_end || Err !== exp_err || Halted !== !exp_err || PC !== pc) begin
                $display("FAIL rand%0d_end: got cyc=%0d Err=%b Halted=%b PC=%h expected %0d/%b/%b/%h",
                         it, e, Err, Halted, PC, exp_end, exp_err, !exp_err, pc); n_fail++; end
            n_checks++; if (run_q.size() != exp_run.size()) begin
                $display("FAIL rand%0d_nruns: got %0d expected %0d", it, run_q.size(), exp_run.size()); n_fail++; end
            for (int i = 0; i < exp_run.size(); i++) begin
                n_checks++; if (q_at(i, run_q) != exp_run[i] || i >= din_q.size() || din_q[i] !== exp_din[i]) begin
                    $display("FAIL rand%0d_run%0d: got cyc=%0d expected cyc=%0d DIN %h", it, i, q_at(i, run_q), exp_run[i], exp_din[i]); n_fail++; end
            end
`ifdef FETCH_PERF_EN
            n_checks++; if (Retired !== 32'(retired)) begin
                $display("FAIL rand%0d_retired: got %0d expected %0d", it, Retired, retired); n_fail++; end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_add_timing();
        test_step_mode();
        test_watchdog();
        test_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
